// File: rtl/program_loader.sv
// program_loader: framed byte-stream loader feeding the CPU program-download port.
// Frame: LEN_LO, LEN_HI (halfword count N), then 2N payload bytes, low byte first.
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte checked in a CHECK state; when undefined the frame ends after the payload.
module program_loader #(
  parameter int MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  input  logic        reload,
  output logic        download_program,
  output logic [31:0] instruction_index,
  output logic [15:0] program_in,
  output logic        load_done,
  output logic        load_error
);

  typedef enum logic [2:0] {
    S_LEN_LO  = 3'd0,
    S_LEN_HI  = 3'd1,
    S_DATA_LO = 3'd2,
    S_DATA_HI = 3'd3,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    S_CHECK   = 3'd4,
`endif
    S_DONE    = 3'd5,
    S_ERROR   = 3'd6
  } state_t;

  // Widened by one bit so the length comparison cannot truncate the limit.
  localparam logic [16:0] MAX_WORDS_C = 17'(MAX_WORDS);

  state_t      state_r;
  logic        byte_ready_r;
  logic        download_r;
  logic        load_done_r;
  logic        load_error_r;
  logic [7:0]  len_lo_r;
  logic [15:0] len_r;
  logic [7:0]  low_r;
  logic [15:0] counter_r;
  logic [15:0] index_r;
  logic [15:0] program_r;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_r;
`endif

  logic        xfer_s;
  logic [15:0] len_s;
  logic [15:0] count_inc_s;

  // Running checksum step: XOR of every payload byte.
  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  assign xfer_s      = byte_valid & byte_ready_r;
  assign len_s       = {byte_data, len_lo_r};
  assign count_inc_s = counter_r + 16'd1;

  assign byte_ready        = byte_ready_r;
  assign download_program  = download_r;
  assign load_done         = load_done_r;
  assign load_error        = load_error_r;
  assign program_in        = program_r;
  assign instruction_index = {16'd0, index_r};

  // Frame FSM; status outputs are registered alongside the state they decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_LEN_LO;
      byte_ready_r <= 1'b1;
      download_r   <= 1'b1;
      load_done_r  <= 1'b0;
      load_error_r <= 1'b0;
      len_lo_r     <= 8'd0;
      len_r        <= 16'd0;
      low_r        <= 8'd0;
      counter_r    <= 16'd0;
      index_r      <= 16'd0;
      program_r    <= 16'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_r       <= 8'd0;
`endif
    end else begin
      case (state_r)
        S_LEN_LO: begin
          if (xfer_s) begin
            len_lo_r <= byte_data;
            state_r  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (xfer_s) begin
            len_r <= len_s;
            if ({1'b0, len_s} > MAX_WORDS_C) begin
              state_r      <= S_ERROR;
              byte_ready_r <= 1'b0;
              load_error_r <= 1'b1;
            end else if (len_s == 16'd0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              state_r      <= S_CHECK;
`else
              state_r      <= S_DONE;
              byte_ready_r <= 1'b0;
              download_r   <= 1'b0;
              load_done_r  <= 1'b1;
`endif
            end else begin
              state_r <= S_DATA_LO;
            end
          end
        end
        S_DATA_LO: begin
          if (xfer_s) begin
            low_r   <= byte_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_r  <= csum_step(csum_r, byte_data);
`endif
            state_r <= S_DATA_HI;
          end
        end
        S_DATA_HI: begin
          if (xfer_s) begin
            program_r <= {byte_data, low_r};
            index_r   <= counter_r;
            counter_r <= count_inc_s;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_r    <= csum_step(csum_r, byte_data);
`endif
            if (count_inc_s == len_r) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              state_r      <= S_CHECK;
`else
              state_r      <= S_DONE;
              byte_ready_r <= 1'b0;
              download_r   <= 1'b0;
              load_done_r  <= 1'b1;
`endif
            end else begin
              state_r <= S_DATA_LO;
            end
          end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (xfer_s) begin
            byte_ready_r <= 1'b0;
            if (byte_data == csum_r) begin
              state_r     <= S_DONE;
              download_r  <= 1'b0;
              load_done_r <= 1'b1;
            end else begin
              state_r      <= S_ERROR;
              load_error_r <= 1'b1;
            end
          end
        end
`endif
        S_DONE, S_ERROR: begin
          // reload has priority over any byte offered in the same cycle
          if (reload) begin
            state_r      <= S_LEN_LO;
            byte_ready_r <= 1'b1;
            download_r   <= 1'b1;
            load_done_r  <= 1'b0;
            load_error_r <= 1'b0;
            counter_r    <= 16'd0;
            index_r      <= 16'd0;
            program_r    <= 16'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_r       <= 8'd0;
`endif
          end
        end
        default: begin
          // unreachable encodings recover to a clean frame start
          state_r      <= S_LEN_LO;
          byte_ready_r <= 1'b1;
          download_r   <= 1'b1;
          load_done_r  <= 1'b0;
          load_error_r <= 1'b0;
          counter_r    <= 16'd0;
          index_r      <= 16'd0;
          program_r    <= 16'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_r       <= 8'd0;
`endif
        end
      endcase
    end
  end

endmodule
